control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/cu_defs.sv | 47 ++++
 rtl/control_unit_if.sv | 30 +++
 rtl/cu_outdec.sv | 59 +++++
 rtl/control_unit.sv | 68 ++++++
 tb/tb_control_unit.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/cu_defs.sv
// Shared opcode, state and control-word definitions for the accumulator CPU control unit.
// Also imported by the datapath bench. A-source encoding 2'b11 (zero) exists but this unit never selects it.
package cu_defs;

  localparam int unsigned OP_W    = 3;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned ASEL_W  = 2;

  typedef enum logic [OP_W-1:0] {
    OP_LOAD  = 3'd0,
    OP_STORE = 3'd1,
    OP_ADD   = 3'd2,
    OP_SUB   = 3'd3,
    OP_IN    = 3'd4,
    OP_JZ    = 3'd5,
    OP_JPOS  = 3'd6,
    OP_HALT  = 3'd7
  } opcode_t;

  typedef enum logic [STATE_W-1:0] {
    S_START  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_INWAIT = 3'd4,
    S_INREL  = 3'd5,
    S_HALTED = 3'd6,
    S_UNUSED = 3'd7
  } state_t;

  localparam logic [ASEL_W-1:0] ASEL_ALU = 2'b00;
  localparam logic [ASEL_W-1:0] ASEL_IN  = 2'b01;
  localparam logic [ASEL_W-1:0] ASEL_RAM = 2'b10;

  typedef struct packed {
    logic              ir_load;
    logic              jmp_mux;
    logic              pc_load;
    logic              mem_inst;
    logic              mem_wr;
    logic              a_load;
    logic              sub;
    logic [ASEL_W-1:0] a_sel;
    logic              halt;
  } ctrl_word_t;

endpackage

// File: rtl/control_unit_if.sv
// Datapath <-> control unit signal bundle; master is the control unit, slave the datapath.
interface control_unit_if;
  import cu_defs::*;

  logic [OP_W-1:0]    IR;
  logic               Aeq0;
  logic               Apos;
  logic               Enter;
  logic               IRload;
  logic               JMPmux;
  logic               PCload;
  logic               Meminst;
  logic               MemWr;
  logic               Aload;
  logic               Sub;
  logic [ASEL_W-1:0]  Asel;
  logic               Halt;
  logic [STATE_W-1:0] State;

  modport master (
    input  IR, Aeq0, Apos, Enter,
    output IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Asel, Halt, State
  );

  modport slave (
    output IR, Aeq0, Apos, Enter,
    input  IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Asel, Halt, State
  );

endinterface

// File: rtl/cu_outdec.sv
// Combinational decoder from FSM state, opcode and status flags to the datapath control word.
module cu_outdec
  import cu_defs::*;
(
  input  state_t     state,
  input  opcode_t    op,
  input  logic       aeq0,
  input  logic       apos,
  input  logic       enter,
  output ctrl_word_t cw
);

  always_comb begin
    cw = '0;
    case (state)
      S_FETCH: begin
        cw.ir_load = 1'b1;
        cw.pc_load = 1'b1;
      end
      S_DECODE: cw.mem_inst = 1'b1;
      S_EXEC: begin
        case (op)
          OP_LOAD: begin
            cw.mem_inst = 1'b1;
            cw.a_sel    = ASEL_RAM;
            cw.a_load   = 1'b1;
          end
          OP_STORE: begin
            cw.mem_inst = 1'b1;
            cw.mem_wr   = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            cw.mem_inst = 1'b1;
            cw.a_sel    = ASEL_ALU;
            cw.sub      = (op == OP_SUB);
            cw.a_load   = 1'b1;
          end
          // Branch flags are only looked at here, in the single EXEC cycle.
          OP_JZ: begin
            cw.jmp_mux = 1'b1;
            cw.pc_load = aeq0;
          end
          OP_JPOS: begin
            cw.jmp_mux = 1'b1;
            cw.pc_load = apos;
          end
          default: ;
        endcase
      end
      S_INWAIT: begin
        cw.a_sel  = ASEL_IN;
        cw.a_load = enter;
      end
      S_HALTED: cw.halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Control unit FSM for the accumulator CPU: fetch/decode/execute sequencing plus IN key handshake.
module control_unit
  import cu_defs::*;
(
  input  logic           Clock,
  input  logic           Reset,
  control_unit_if.master bus
);

  state_t     state;
  state_t     state_next;
  logic       released;
  opcode_t    op;
  ctrl_word_t cw;

  assign op = opcode_t'(bus.IR);

  // released holds START for one extra edge after reset drops, so FETCH lands on the second edge.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= S_START;
      released <= 1'b0;
    end else begin
      state    <= state_next;
      released <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_START:  if (released) state_next = S_FETCH;
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        if (op == OP_IN)        state_next = S_INWAIT;
        else if (op == OP_HALT) state_next = S_HALTED;
        else                    state_next = S_EXEC;
      end
      S_EXEC:   state_next = S_FETCH;
      S_INWAIT: if (bus.Enter) state_next = S_INREL;
      // INREL waits for key release so one press loads A only once.
      S_INREL:  if (!bus.Enter) state_next = S_FETCH;
      S_HALTED: state_next = S_HALTED;
      default:  state_next = S_START;
    endcase
  end

  cu_outdec u_outdec (
    .state (state),
    .op    (op),
    .aeq0  (bus.Aeq0),
    .apos  (bus.Apos),
    .enter (bus.Enter),
    .cw    (cw)
  );

  assign bus.IRload  = cw.ir_load;
  assign bus.JMPmux  = cw.jmp_mux;
  assign bus.PCload  = cw.pc_load;
  assign bus.Meminst = cw.mem_inst;
  assign bus.MemWr   = cw.mem_wr;
  assign bus.Aload   = cw.a_load;
  assign bus.Sub     = cw.sub;
  assign bus.Asel    = cw.a_sel;
  assign bus.Halt    = cw.halt;
  assign bus.State   = STATE_W'(state);

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed vector table, multi-cycle corner sequences,
// and random instruction streams checked against an instruction-level model.
module tb_control_unit;
  import cu_defs::*;

  typedef struct packed {
    logic [2:0] st;
    logic       irl, jmp, pcl, mi, mw, al, sb;
    logic [1:0] asel;
    logic       halt;
  } obs_t;

  typedef struct {
    logic [2:0] ir;
    logic       aeq0;
    logic       apos;
    obs_t       exp;
  } vec_t;

  logic Clock;
  logic Reset;
  int   checks;
  int   errors;

  control_unit_if bus ();

  control_unit dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic obs_t get_obs();
    obs_t o;
    o = {bus.State, bus.IRload, bus.JMPmux, bus.PCload, bus.Meminst, bus.MemWr,
         bus.Aload, bus.Sub, bus.Asel, bus.Halt};
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Assert reset mid-cycle, check outputs clear, release, and stop one edge later (still START).
  task automatic do_reset();
    Reset = 1'b1;
    #1;
    chk("reset_outputs_zero", 32'(get_obs()), 32'(0));
    @(posedge Clock);
    #2;
    Reset = 1'b0;
    tick();
    chk("reset_edge1_start", 32'(bus.State), 32'(0));
  endtask

  localparam obs_t W_FETCH  = {3'd1, 7'b1010000, 2'b00, 1'b0};
  localparam obs_t W_DECODE = {3'd2, 7'b0001000, 2'b00, 1'b0};
  localparam obs_t W_INWAIT = {3'd4, 7'b0000000, 2'b01, 1'b0};
  localparam obs_t W_HALTED = {3'd6, 7'b0000000, 2'b00, 1'b1};

  initial begin
    vec_t tbl [8];
    obs_t o;
    int   n_al, n_good;

    checks = 0;
    errors = 0;
    Reset  = 1'b1;
    bus.IR = 3'd0; bus.Aeq0 = 1'b0; bus.Apos = 1'b0; bus.Enter = 1'b0;
    #12;

    tbl[0] = '{3'd0, 1'b0, 1'b0, obs_t'({3'd3, 7'b0001010, 2'b10, 1'b0})}; // LOAD
    tbl[1] = '{3'd1, 1'b1, 1'b1, obs_t'({3'd3, 7'b0001100, 2'b00, 1'b0})}; // STORE
    tbl[2] = '{3'd2, 1'b1, 1'b0, obs_t'({3'd3, 7'b0001010, 2'b00, 1'b0})}; // ADD
    tbl[3] = '{3'd3, 1'b0, 1'b1, obs_t'({3'd3, 7'b0001011, 2'b00, 1'b0})}; // SUB
    tbl[4] = '{3'd5, 1'b1, 1'b0, obs_t'({3'd3, 7'b0110000, 2'b00, 1'b0})}; // JZ taken
    tbl[5] = '{3'd5, 1'b0, 1'b1, obs_t'({3'd3, 7'b0100000, 2'b00, 1'b0})}; // JZ not taken
    tbl[6] = '{3'd6, 1'b0, 1'b1, obs_t'({3'd3, 7'b0110000, 2'b00, 1'b0})}; // JPOS taken
    tbl[7] = '{3'd6, 1'b1, 1'b0, obs_t'({3'd3, 7'b0100000, 2'b00, 1'b0})}; // JPOS not taken

    for (int i = 0; i < 8; i++) begin
      bus.IR = tbl[i].ir; bus.Aeq0 = tbl[i].aeq0; bus.Apos = tbl[i].apos; bus.Enter = 1'b0;
      do_reset();
      tick();
      chk($sformatf("vec%0d_fetch", i), 32'(get_obs()), 32'(W_FETCH));
      tick();
      chk($sformatf("vec%0d_decode", i), 32'(get_obs()), 32'(W_DECODE));
      tick();
      chk($sformatf("vec%0d_exec", i), 32'(get_obs()), 32'(tbl[i].exp));
      tick();
      chk($sformatf("vec%0d_next_fetch", i), 32'(bus.State), 32'(1));
    end

    // IN with Enter held for 5 cycles: one Aload with Asel=01, FETCH one edge after release.
    bus.IR = 3'd4; bus.Enter = 1'b0;
    do_reset();
    tick(); tick(); tick();
    chk("in_wait_idle", 32'(get_obs()), 32'(W_INWAIT));
    tick();
    n_al = 0;
    for (int c = 0; c < 5; c++) begin
      bus.Enter = 1'b1;
      #1;
      if (bus.Aload && bus.Asel == 2'b01) n_al++;
      else if (bus.Aload) n_al += 100;
      tick();
    end
    bus.Enter = 1'b0;
    #1;
    chk("in_release_state", 32'(bus.State), 32'(5));
    if (bus.Aload) n_al++;
    chk("in_aload_once", 32'(n_al), 32'(1));
    tick();
    chk("in_fetch_after_release", 32'(bus.State), 32'(1));

    // Reset from INWAIT behaves like any other reset.
    bus.IR = 3'd4;
    do_reset();
    tick(); tick(); tick();
    chk("inwait_before_reset", 32'(bus.State), 32'(4));
    Reset = 1'b1;
    #1;
    chk("inwait_reset_async", 32'(get_obs()), 32'(0));
    @(posedge Clock); #2; Reset = 1'b0;
    tick();
    chk("inwait_rel_edge1", 32'(bus.State), 32'(0));
    tick();
    chk("inwait_rel_edge2", 32'(bus.State), 32'(1));

    // Reset during STORE EXEC: MemWr drops before the next edge.
    bus.IR = 3'd1;
    do_reset();
    tick(); tick(); tick();
    chk("store_exec_memwr", 32'({bus.MemWr, bus.Meminst}), 32'(3));
    #2;
    Reset = 1'b1;
    #1;
    chk("store_reset_memwr", 32'(bus.MemWr), 32'(0));
    chk("store_reset_state", 32'(bus.State), 32'(0));

    // HALT: stays halted for 22 cycles regardless of inputs, cleared asynchronously by reset.
    bus.IR = 3'd7;
    do_reset();
    tick(); tick(); tick();
    n_good = 0;
    for (int c = 0; c < 22; c++) begin
      bus.Enter = 1'($urandom); bus.Aeq0 = 1'($urandom); bus.Apos = 1'($urandom);
      bus.IR = 3'($urandom);
      #1;
      if (get_obs() === W_HALTED) n_good++;
      tick();
    end
    chk("halt_held_cycles", 32'(n_good), 32'(22));
    #2;
    Reset = 1'b1;
    #1;
    chk("halt_reset_async", 32'(bus.Halt), 32'(0));
    @(posedge Clock); #2; Reset = 1'b0;
    tick();
    chk("halt_rel_edge1", 32'(bus.State), 32'(0));
    tick();
    chk("halt_rel_edge2", 32'(bus.State), 32'(1));

    // Random instruction stream against an instruction-level model.
    bus.Enter = 1'b0;
    do_reset();
    tick();
    for (int k = 0; k < 40; k++) begin
      int op, w, h, len;
      int r_al, r_mw, r_pc, r_jmp, r_irl, r_halt, r_bad;
      logic ez, ep, l_sb;
      logic [1:0] l_asel;
      int e_al, e_mw, e_pc, e_jmp;
      logic e_sb;
      logic [1:0] e_asel;
      op  = int'($urandom_range(0, 6));
      w   = int'($urandom_range(0, 3));
      h   = int'($urandom_range(1, 4));
      len = (op == 4) ? 3 + w + h : 3;
      r_al = 0; r_mw = 0; r_pc = 0; r_jmp = 0; r_irl = 0; r_halt = 0; r_bad = 0;
      ez = 1'b0; ep = 1'b0; l_sb = 1'b0; l_asel = 2'b00;
      bus.IR = 3'(op);
      for (int c = 0; c < len; c++) begin
        bus.Aeq0 = 1'($urandom);
        bus.Apos = 1'($urandom);
        if (op == 4) bus.Enter = (c >= 2 + w && c < 2 + w + h) ? 1'b1 : 1'b0;
        else         bus.Enter = 1'($urandom);
        if (c == 2) begin ez = bus.Aeq0; ep = bus.Apos; end
        #1;
        o = get_obs();
        if (o.al) begin r_al++; l_asel = o.asel; l_sb = o.sb; end
        if (o.mw) begin r_mw++; if (!o.mi) r_bad++; end
        r_pc   += int'(o.pcl);
        r_jmp  += int'(o.jmp);
        r_irl  += int'(o.irl);
        r_halt += int'(o.halt);
        tick();
      end
      bus.Enter = 1'b0;
      e_al   = (op == 0 || op == 2 || op == 3 || op == 4) ? 1 : 0;
      e_mw   = (op == 1) ? 1 : 0;
      e_jmp  = (op == 5 || op == 6) ? 1 : 0;
      e_pc   = 1 + (((op == 5 && ez) || (op == 6 && ep)) ? 1 : 0);
      e_asel = (op == 0) ? 2'b10 : (op == 4) ? 2'b01 : 2'b00;
      e_sb   = (op == 3);
      chk($sformatf("rand%0d_op%0d_len", k, op), 32'(bus.State), 32'(1));
      chk($sformatf("rand%0d_op%0d_aload", k, op), 32'(r_al), 32'(e_al));
      chk($sformatf("rand%0d_op%0d_memwr", k, op), 32'(r_mw), 32'(e_mw));
      chk($sformatf("rand%0d_op%0d_pcload", k, op), 32'(r_pc), 32'(e_pc));
      chk($sformatf("rand%0d_op%0d_jmpmux", k, op), 32'(r_jmp), 32'(e_jmp));
      chk($sformatf("rand%0d_op%0d_misc", k, op), 32'({8'(r_irl), 8'(r_halt), 8'(r_bad)}),
          32'({8'd1, 8'd0, 8'd0}));
      if (e_al == 1)
        chk($sformatf("rand%0d_op%0d_asel_sub", k, op), 32'({l_sb, l_asel}), 32'({e_sb, e_asel}));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
